// File: rtl/seg_decoder.sv
// Registered hex-to-seven-segment decoder with lamp test, blanking and ripple zero-blanking.
// Define SEG_DP_EN to add the dp_in request input and the registered active-low dp output.
module seg_decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] number,
    input  logic       blank,
    input  logic       lamp_test,
    input  logic       rbi,
`ifdef SEG_DP_EN
    input  logic       dp_in,
    output logic       dp,
`endif
    output logic [6:0] cathode,
    output logic       rbo
);

    logic [6:0] glyph;
    logic [6:0] cathode_next;
    logic       rbo_next;
    logic       zero_suppress;

    // Active-low, bit order g..a
    always_comb begin
        glyph = 7'h7F;
        unique case (number)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
        endcase
    end

    assign zero_suppress = rbi && (number == 4'h0);

    // Priority: lamp_test > blank > zero-suppress > glyph
    always_comb begin
        cathode_next = glyph;
        rbo_next     = 1'b0;
        if (lamp_test) begin
            cathode_next = 7'h00;
        end else if (blank) begin
            cathode_next = 7'h7F;
        end else if (zero_suppress) begin
            cathode_next = 7'h7F;
            rbo_next     = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cathode <= 7'h7F;
            rbo     <= 1'b0;
        end else begin
            cathode <= cathode_next;
            rbo     <= rbo_next;
        end
    end

`ifdef SEG_DP_EN
    logic dp_next;

    always_comb begin
        dp_next = ~dp_in;
        if (lamp_test) begin
            dp_next = 1'b0;
        end else if (blank || zero_suppress) begin
            dp_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dp <= 1'b1;
        end else begin
            dp <= dp_next;
        end
    end
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Self-checking bench for seg_decoder: directed scenarios plus randomized traffic against a table model.
// Exercises the decimal-point path too when SEG_DP_EN is defined.
module tb_seg_decoder;

    logic       clock;
    logic       reset;
    logic [3:0] number;
    logic       blank;
    logic       lamp_test;
    logic       rbi;
    logic [6:0] cathode;
    logic       rbo;
`ifdef SEG_DP_EN
    logic       dp_in;
    logic       dp;
`endif

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .number    (number),
        .blank     (blank),
        .lamp_test (lamp_test),
        .rbi       (rbi),
`ifdef SEG_DP_EN
        .dp_in     (dp_in),
        .dp        (dp),
`endif
        .cathode   (cathode),
        .rbo       (rbo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] exp_cathode(input logic [3:0] n, input logic b,
                                               input logic l, input logic r);
        if (l) return 7'h00;
        if (b) return 7'h7F;
        if (r && n == 4'd0) return 7'h7F;
        return glyph_tab[n];
    endfunction

    function automatic logic exp_rbo(input logic [3:0] n, input logic b,
                                     input logic l, input logic r);
        return !l && !b && r && (n == 4'd0);
    endfunction

    function automatic logic exp_dp(input logic [3:0] n, input logic b, input logic l,
                                    input logic r, input logic d);
        if (l) return 1'b0;
        if (b || (r && n == 4'd0)) return 1'b1;
        return ~d;
    endfunction

    task automatic drive(input logic [3:0] n, input logic b, input logic l, input logic r);
        number    = n;
        blank     = b;
        lamp_test = l;
        rbi       = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(4'h8, 1'b0, 1'b0, 1'b0);
`ifdef SEG_DP_EN
        dp_in = 1'b1;
`endif
        #1 reset = 1'b1;
        #1;
        total++;
        if (cathode !== 7'h7F || rbo !== 1'b0) begin
            bad++;
            $display("FAIL reset_async cathode=%h rbo=%b expected cathode=7f rbo=0", cathode, rbo);
        end
`ifdef SEG_DP_EN
        total++;
        if (dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_dp dp=%b expected 1", dp);
        end
`endif
        tick();
        tick();
        total++;
        if (cathode !== 7'h7F || rbo !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cathode=%h rbo=%b expected cathode=7f rbo=0", cathode, rbo);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        total++;
        if (cathode !== 7'h00) begin
            bad++;
            $display("FAIL reset_release cathode=%h expected 00", cathode);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 1'b0, 1'b0, 1'b0);
            tick();
            total++;
            if (cathode !== glyph_tab[i] || rbo !== 1'b0) begin
                bad++;
                $display("FAIL sweep_%0h cathode=%h rbo=%b expected cathode=%h rbo=0",
                         i, cathode, rbo, glyph_tab[i]);
            end
        end
    endtask

    task automatic test_priority();
        drive(4'h5, 1'b1, 1'b1, 1'b1);
        tick();
        total++;
        if (cathode !== 7'h00) begin
            bad++;
            $display("FAIL prio_lamp cathode=%h expected 00", cathode);
        end
        lamp_test = 1'b0;
        tick();
        total++;
        if (cathode !== 7'h7F) begin
            bad++;
            $display("FAIL prio_blank cathode=%h expected 7f", cathode);
        end
        blank = 1'b0;
        tick();
        total++;
        if (cathode !== 7'h12) begin
            bad++;
            $display("FAIL prio_glyph cathode=%h expected 12", cathode);
        end
        // all overrides with a zero digit: lamp test must still win and rbo stay low
        drive(4'h0, 1'b1, 1'b1, 1'b1);
        tick();
        total++;
        if (cathode !== 7'h00 || rbo !== 1'b0) begin
            bad++;
            $display("FAIL prio_zero cathode=%h rbo=%b expected cathode=00 rbo=0", cathode, rbo);
        end
    endtask

    task automatic test_ripple();
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        total++;
        if (cathode !== 7'h7F || rbo !== 1'b1) begin
            bad++;
            $display("FAIL ripple_zero cathode=%h rbo=%b expected cathode=7f rbo=1", cathode, rbo);
        end
        drive(4'h3, 1'b0, 1'b0, 1'b1);
        tick();
        total++;
        if (cathode !== 7'h30 || rbo !== 1'b0) begin
            bad++;
            $display("FAIL ripple_three cathode=%h rbo=%b expected cathode=30 rbo=0", cathode, rbo);
        end
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (cathode !== 7'h40 || rbo !== 1'b0) begin
            bad++;
            $display("FAIL ripple_off cathode=%h rbo=%b expected cathode=40 rbo=0", cathode, rbo);
        end
    endtask

    task automatic test_midstream_reset();
        drive(4'hA, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (cathode !== 7'h08) begin
            bad++;
            $display("FAIL mid_before cathode=%h expected 08", cathode);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (cathode !== 7'h7F || rbo !== 1'b0) begin
            bad++;
            $display("FAIL mid_async cathode=%h rbo=%b expected cathode=7f rbo=0", cathode, rbo);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        total++;
        if (cathode !== 7'h08) begin
            bad++;
            $display("FAIL mid_release cathode=%h expected 08", cathode);
        end
    endtask

`ifdef SEG_DP_EN
    task automatic test_dp();
        dp_in = 1'b1;
        drive(4'h1, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (cathode !== 7'h79 || dp !== 1'b0) begin
            bad++;
            $display("FAIL dp_on cathode=%h dp=%b expected cathode=79 dp=0", cathode, dp);
        end
        blank = 1'b1;
        tick();
        total++;
        if (dp !== 1'b1) begin
            bad++;
            $display("FAIL dp_blank dp=%b expected 1", dp);
        end
        lamp_test = 1'b1;
        dp_in     = 1'b0;
        tick();
        total++;
        if (dp !== 1'b0) begin
            bad++;
            $display("FAIL dp_lamp dp=%b expected 0", dp);
        end
    endtask
`endif

    // Inputs change every cycle; each output must track exactly the previous cycle's inputs
    task automatic test_random();
        logic [3:0] n;
        logic       b, l, r;
        logic [6:0] ec;
        logic       er;
`ifdef SEG_DP_EN
        logic       d;
        logic       ed;
`endif
        for (int i = 0; i < 300; i++) begin
            n = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom);
            b = (($urandom % 6) == 0);
            l = (($urandom % 6) == 0);
            r = $urandom % 2;
            drive(n, b, l, r);
            ec = exp_cathode(n, b, l, r);
            er = exp_rbo(n, b, l, r);
`ifdef SEG_DP_EN
            d     = $urandom % 2;
            dp_in = d;
            ed    = exp_dp(n, b, l, r, d);
`endif
            tick();
            total++;
            if (cathode !== ec || rbo !== er) begin
                bad++;
                $display("FAIL random_%0d n=%h b=%b l=%b r=%b cathode=%h rbo=%b expected cathode=%h rbo=%b",
                         i, n, b, l, r, cathode, rbo, ec, er);
            end
`ifdef SEG_DP_EN
            total++;
            if (dp !== ed) begin
                bad++;
                $display("FAIL random_dp_%0d dp=%b expected %b", i, dp, ed);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 1'b0);
`ifdef SEG_DP_EN
        dp_in = 1'b0;
`endif
        test_reset();
        test_sweep();
        test_priority();
        test_ripple();
        test_midstream_reset();
`ifdef SEG_DP_EN
        test_dp();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
